// File: rtl/txshift_pkg.sv
// Shared definitions for the parametrised UART transmitter: parity modes,
// FSM state encoding and elaboration-time legality checks.
package txshift_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] PAR_MARK = 2'b11;

  localparam int unsigned DATA_W_MIN = 5;
  localparam int unsigned DATA_W_MAX = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  function automatic bit data_w_ok(input int unsigned w);
    return (w >= DATA_W_MIN) && (w <= DATA_W_MAX);
  endfunction

  function automatic bit depth_ok(input int unsigned d);
    return (d >= 2) && ((d & (d - 1)) == 0);
  endfunction

  // Data is zero-extended to the widest legal frame; extra zeros do not change the XOR.
  function automatic logic parity_bit(input logic [1:0] mode,
                                      input logic [DATA_W_MAX-1:0] d);
    logic p;
    case (mode)
      PAR_EVEN: p = ^d;
      PAR_ODD:  p = ~^d;
      default:  p = 1'b1;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/txshift_param_txfifo.sv
// Synchronous input FIFO for the transmitter; pointers carry one extra wrap bit
// so full and empty are distinguished without a separate counter.
module txfifo
  import txshift_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_q, rd_q, wr_d, rd_d;
  logic              full_q;
  logic              do_push, do_pop;

  assign empty   = (wr_q == rd_q);
  assign full    = full_q;
  assign do_push = push & ~full_q;
  assign do_pop  = pop & ~empty;
  assign wr_d    = wr_q + PW'(do_push);
  assign rd_d    = rd_q + PW'(do_pop);
  assign count   = CW'(wr_q - rd_q);
  assign head    = mem[rd_q[AW-1:0]];

  // Full is registered from the next-state pointers so it always agrees with count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      full_q <= ((wr_d - rd_d) == PW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/txshift_param.sv
// UART transmitter with integrated per-frame baud divider, input FIFO and
// runtime parity / stop-bit selection latched at each frame load.
module txshift_param
  import txshift_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned BAUD_W = 14
) (
  input  logic                       i_Pclk,
  input  logic                       i_Reset,
  input  logic [BAUD_W-1:0]          i_Baud,
  input  logic [1:0]                 i_Parity,
  input  logic                       i_Stop2,
  input  logic                       i_Enable,
  input  logic [DATA_W-1:0]          i_Data,
  output logic                       o_Tx_Serial,
  output logic                       o_Pready,
  output logic                       o_Busy,
  output logic [$clog2(DEPTH+1)-1:0] o_Count,
  output logic                       o_Ovf
);

  localparam int unsigned BW = $clog2(DATA_W);

  if (!data_w_ok(DATA_W) || !depth_ok(DEPTH)) begin : g_cfg_err
    $error("txshift_param: DATA_W must be 5..9 and DEPTH a power of 2 >= 2");
  end

  tx_state_e         state_q, state_d;
  logic              tx_q, tx_d;
  logic [BAUD_W-1:0] baud_cnt_q, baud_cnt_d;
  logic [BAUD_W-1:0] baud_div_q, baud_div_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
  logic              stop2_q, stop2_d;
  logic              stop_sec_q, stop_sec_d;
  logic              ovf_q;

  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  logic              bit_end, last_stop, load;

  assign fifo_push = i_Enable & ~fifo_full;

  txfifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (i_Pclk),
    .rst   (i_Reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (i_Data),
    .head  (fifo_head),
    .count (o_Count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bit_end   = (baud_cnt_q == baud_div_q - BAUD_W'(1));
  assign last_stop = ~stop2_q | stop_sec_q;
  // Back-to-back load happens on the final stop cycle so frames abut with no idle gap.
  assign load      = ~fifo_empty &
                     ((state_q == ST_IDLE) | ((state_q == ST_STOP) & bit_end & last_stop));
  assign fifo_pop  = load;

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    baud_cnt_d = bit_end ? '0 : baud_cnt_q + BAUD_W'(1);
    baud_div_d = baud_div_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_sec_d = stop_sec_q;

    case (state_q)
      ST_IDLE: begin
        tx_d       = 1'b1;
        baud_cnt_d = '0;
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          tx_d      = shreg_q[0];
          shreg_d   = shreg_q >> 1;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == BW'(DATA_W - 1)) begin
            if (par_en_q) begin
              state_d = ST_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = ST_STOP;
              tx_d       = 1'b1;
              stop_sec_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
            tx_d      = shreg_q[0];
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          tx_d       = 1'b1;
          stop_sec_d = 1'b0;
        end
      end
      ST_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          if (!last_stop) begin
            stop_sec_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame configuration is captured only here, so mid-frame changes wait for the next load.
    if (load) begin
      state_d    = ST_START;
      tx_d       = 1'b0;
      baud_cnt_d = '0;
      baud_div_d = (i_Baud == '0) ? BAUD_W'(1) : i_Baud;
      bit_cnt_d  = '0;
      shreg_d    = fifo_head;
      par_en_d   = (i_Parity != PAR_NONE);
      par_bit_d  = parity_bit(i_Parity, DATA_W_MAX'(fifo_head));
      stop2_d    = i_Stop2;
      stop_sec_d = 1'b0;
    end
  end

  always_ff @(posedge i_Pclk) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      tx_q       <= 1'b1;
      baud_cnt_q <= '0;
      baud_div_q <= BAUD_W'(1);
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_sec_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      baud_cnt_q <= baud_cnt_d;
      baud_div_q <= baud_div_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_sec_q <= stop_sec_d;
      ovf_q      <= ovf_q | (i_Enable & fifo_full);
    end
  end

  assign o_Tx_Serial = tx_q;
  assign o_Pready    = ~fifo_full;
  assign o_Busy      = (state_q != ST_IDLE);
  assign o_Ovf       = ovf_q;

endmodule

// File: tb/tb_txshift_param.sv
// Directed bench for txshift_param: table of single frames, plus FIFO fill,
// mid-frame config change and mid-frame reset sequences.
module tb_txshift_param;

  logic        clk = 1'b0;
  logic        i_Reset = 1'b1;
  logic [13:0] i_Baud = 14'd4;
  logic [1:0]  i_Parity = 2'b00;
  logic        i_Stop2 = 1'b0;
  logic        i_Enable = 1'b0;
  logic [7:0]  i_Data = 8'h00;
  logic        o_Tx_Serial, o_Pready, o_Busy, o_Ovf;
  logic [2:0]  o_Count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  txshift_param #(
    .DATA_W (8),
    .DEPTH  (4),
    .BAUD_W (14)
  ) dut (
    .i_Pclk      (clk),
    .i_Reset     (i_Reset),
    .i_Baud      (i_Baud),
    .i_Parity    (i_Parity),
    .i_Stop2     (i_Stop2),
    .i_Enable    (i_Enable),
    .i_Data      (i_Data),
    .o_Tx_Serial (o_Tx_Serial),
    .o_Pready    (o_Pready),
    .o_Busy      (o_Busy),
    .o_Count     (o_Count),
    .o_Ovf       (o_Ovf)
  );

  typedef struct {
    logic [7:0] data;
    logic [1:0] par;
    logic       s2;
    int         baud;
    logic       exp_par;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] d);
    i_Data   = d;
    i_Enable = 1'b1;
    @(negedge clk);
    i_Enable = 1'b0;
  endtask

  // Expects the first start-bit cycle on the next falling edge.
  task automatic check_frame(input logic [7:0] d, input logic has_par, input logic pbit,
                             input logic s2, input int b);
    logic lv[$];
    int per;
    per = (b == 0) ? 1 : b;
    lv.push_back(1'b0);
    for (int i = 0; i < 8; i++) lv.push_back(d[i]);
    if (has_par) lv.push_back(pbit);
    lv.push_back(1'b1);
    if (s2) lv.push_back(1'b1);
    for (int k = 0; k < lv.size(); k++) begin
      for (int c = 0; c < per; c++) begin
        @(negedge clk);
        chk($sformatf("line d=%02h lvl%0d", d, k), 32'(o_Tx_Serial), 32'(lv[k]));
        chk($sformatf("busy d=%02h lvl%0d", d, k), 32'(o_Busy), 32'd1);
      end
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    chk({tag, " idle busy"}, 32'(o_Busy), 32'd0);
    chk({tag, " idle line"}, 32'(o_Tx_Serial), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{data: 8'h53, par: 2'b00, s2: 1'b0, baud: 4, exp_par: 1'b0};
    vecs[1] = '{data: 8'h53, par: 2'b01, s2: 1'b0, baud: 4, exp_par: 1'b0};
    vecs[2] = '{data: 8'h53, par: 2'b10, s2: 1'b0, baud: 4, exp_par: 1'b1};
    vecs[3] = '{data: 8'h53, par: 2'b00, s2: 1'b1, baud: 4, exp_par: 1'b0};
    vecs[4] = '{data: 8'hFF, par: 2'b11, s2: 1'b0, baud: 1, exp_par: 1'b1};
    vecs[5] = '{data: 8'h00, par: 2'b10, s2: 1'b0, baud: 0, exp_par: 1'b1};
    vecs[6] = '{data: 8'h80, par: 2'b01, s2: 1'b1, baud: 3, exp_par: 1'b1};
    vecs[7] = '{data: 8'hA5, par: 2'b10, s2: 1'b0, baud: 2, exp_par: 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst line",   32'(o_Tx_Serial), 32'd1);
    chk("rst pready", 32'(o_Pready),    32'd1);
    chk("rst busy",   32'(o_Busy),      32'd0);
    chk("rst count",  32'(o_Count),     32'd0);
    chk("rst ovf",    32'(o_Ovf),       32'd0);
    i_Reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      i_Parity = vecs[i].par;
      i_Stop2  = vecs[i].s2;
      i_Baud   = 14'(vecs[i].baud);
      push(vecs[i].data);
      check_frame(vecs[i].data, vecs[i].par != 2'b00, vecs[i].exp_par, vecs[i].s2, vecs[i].baud);
      check_idle($sformatf("vec%0d", i));
    end

    // FIFO fill: five accepted, sixth dropped, frames sent back to back
    i_Parity = 2'b00;
    i_Stop2  = 1'b0;
    i_Baud   = 14'd4;
    fork
      begin
        i_Enable = 1'b1;
        for (int w = 1; w <= 6; w++) begin
          i_Data = 8'(w);
          @(negedge clk);
          if (w == 5) begin
            chk("fill count after 5", 32'(o_Count),  32'd4);
            chk("fill pready after 5", 32'(o_Pready), 32'd0);
            chk("fill ovf after 5",   32'(o_Ovf),    32'd0);
          end
        end
        i_Enable = 1'b0;
        chk("fill ovf after 6",   32'(o_Ovf),   32'd1);
        chk("fill count after 6", 32'(o_Count), 32'd4);
      end
      begin
        @(negedge clk);
        for (int w = 1; w <= 5; w++) check_frame(8'(w), 1'b0, 1'b0, 1'b0, 4);
      end
    join
    check_idle("fill");
    chk("fill count drained", 32'(o_Count), 32'd0);

    // Mid-frame config change affects only the following frame
    i_Data   = 8'h3C;
    i_Enable = 1'b1;
    @(negedge clk);
    i_Data   = 8'hC1;
    fork
      begin
        @(negedge clk);
        i_Enable = 1'b0;
        repeat (10) @(negedge clk);
        i_Parity = 2'b01;
        i_Baud   = 14'd8;
      end
      begin
        check_frame(8'h3C, 1'b0, 1'b0, 1'b0, 4);
        check_frame(8'hC1, 1'b1, 1'b1, 1'b0, 8);
      end
    join
    check_idle("cfgchg");
    i_Parity = 2'b00;
    i_Baud   = 14'd4;

    // Reset during data bit 3 aborts the frame
    push(8'h52);
    for (int k = 1; k <= 18; k++) @(negedge clk);
    chk("pre-reset bit3 line", 32'(o_Tx_Serial), 32'd0);
    chk("pre-reset ovf sticky", 32'(o_Ovf), 32'd1);
    i_Reset = 1'b1;
    @(negedge clk);
    chk("midrst line",   32'(o_Tx_Serial), 32'd1);
    chk("midrst busy",   32'(o_Busy),      32'd0);
    chk("midrst count",  32'(o_Count),     32'd0);
    chk("midrst pready", 32'(o_Pready),    32'd1);
    chk("midrst ovf",    32'(o_Ovf),       32'd0);
    i_Reset = 1'b0;
    @(negedge clk);
    push(8'hA5);
    check_frame(8'hA5, 1'b0, 1'b0, 1'b0, 4);
    check_idle("postrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
